// File: rtl/screen_sequencer_if.sv
// screen_sequencer_if: button/frame event inputs and screen-control outputs
// of the menu screen sequencer, grouped for connection as a single port.
interface screen_sequencer_if;
  logic       frame_tick;
  logic       left_tick;
  logic       right_tick;
  logic       select_tick;
  logic       back_tick;
  logic [2:0] cursor_index;
  logic [9:0] cursor_x;
  logic       pinta_pantalla_principal;
  logic       pinta_pantalla_opcion;
  logic [2:0] opcion_activa;
  logic       cerrar;
  logic       nuevo;

  // Event source side (board inputs / bench)
  modport master (
    output frame_tick, left_tick, right_tick, select_tick, back_tick,
    input  cursor_index, cursor_x, pinta_pantalla_principal,
           pinta_pantalla_opcion, opcion_activa, cerrar, nuevo
  );

  // Sequencer side
  modport slave (
    input  frame_tick, left_tick, right_tick, select_tick, back_tick,
    output cursor_index, cursor_x, pinta_pantalla_principal,
           pinta_pantalla_opcion, opcion_activa, cerrar, nuevo
  );
endinterface

// File: rtl/screen_sequencer.sv
// screen_sequencer: frame-synchronous menu state machine (BLANK/MENU/OPTION/
// CLOSE). Button ticks are collected into a single pending event that is
// applied on the next frame_tick. Idle frames in MENU time out to BLANK.
// Optional macro CURSOR_WRAP_EN: cursor wraps 4->0 / 0->4 instead of
// saturating at the ends.
module screen_sequencer #(
  parameter int unsigned TIMEOUT_FRAMES = 1800
) (
  input  logic          clk,
  input  logic          reset,
  screen_sequencer_if.slave bus
);

  localparam logic [10:0] LP_TIMEOUT = TIMEOUT_FRAMES[10:0];

  typedef enum logic [1:0] {
    ST_BLANK,
    ST_MENU,
    ST_OPTION,
    ST_CLOSE
  } state_t;

  typedef enum logic [2:0] {
    EV_NONE,
    EV_LEFT,
    EV_RIGHT,
    EV_BACK,
    EV_SELECT
  } event_t;

  state_t      r_state;
  event_t      r_pend;
  logic [10:0] r_idle;
  logic [2:0]  r_cursor;
  logic [9:0]  r_cursor_x;
  logic        r_principal;
  logic        r_opcion;
  logic [2:0]  r_opcion_activa;
  logic        r_cerrar;
  logic        r_nuevo;

  event_t      w_tick_ev;
  event_t      w_base;
  event_t      w_pend_next;
  logic [2:0]  w_cur_up;
  logic [2:0]  w_cur_dn;
  logic [10:0] w_idle_inc;

  function automatic logic [9:0] cursor_pos(input logic [2:0] idx);
    logic [9:0] pos;
    case (idx)
      3'd0:    pos = 10'd16;
      3'd1:    pos = 10'd93;
      3'd2:    pos = 10'd180;
      3'd3:    pos = 10'd480;
      3'd4:    pos = 10'd557;
      default: pos = 10'd16;
    endcase
    return pos;
  endfunction

  // Strongest event among this cycle's ticks; opposing moves cancel out
  always_comb begin
    w_tick_ev = EV_NONE;
    if (bus.select_tick)
      w_tick_ev = EV_SELECT;
    else if (bus.back_tick)
      w_tick_ev = EV_BACK;
    else if (bus.left_tick && !bus.right_tick)
      w_tick_ev = EV_LEFT;
    else if (bus.right_tick && !bus.left_tick)
      w_tick_ev = EV_RIGHT;
  end

  // Merge into pending slot: frame_tick consumes the old slot first, so a
  // tick on the frame edge lands in an empty slot for the following frame
  always_comb begin
    w_base      = bus.frame_tick ? EV_NONE : r_pend;
    w_pend_next = w_base;
    case (w_tick_ev)
      EV_SELECT: w_pend_next = EV_SELECT;
      EV_BACK:   if (w_base != EV_SELECT) w_pend_next = EV_BACK;
      EV_LEFT, EV_RIGHT:
        if (w_base != EV_SELECT && w_base != EV_BACK) w_pend_next = w_tick_ev;
      default: ;
    endcase
  end

  // Neighbour cursor positions and next idle count
  always_comb begin
`ifdef CURSOR_WRAP_EN
    w_cur_up = (r_cursor == 3'd4) ? '0    : r_cursor + 3'd1;
    w_cur_dn = (r_cursor == 3'd0) ? 3'd4  : r_cursor - 3'd1;
`else
    w_cur_up = (r_cursor == 3'd4) ? 3'd4  : r_cursor + 3'd1;
    w_cur_dn = (r_cursor == 3'd0) ? 3'd0  : r_cursor - 3'd1;
`endif
    w_idle_inc = r_idle + 11'd1;
  end

  // Screen FSM with registered outputs and pending-event register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= ST_BLANK;
      r_pend          <= EV_NONE;
      r_idle          <= '0;
      r_cursor        <= '0;
      r_cursor_x      <= 10'd16;
      r_principal     <= 1'b0;
      r_opcion        <= 1'b0;
      r_opcion_activa <= '0;
      r_cerrar        <= 1'b0;
      r_nuevo         <= 1'b0;
    end else begin
      r_pend   <= w_pend_next;
      r_nuevo  <= 1'b0;
      r_cerrar <= 1'b0;
      case (r_state)
        ST_BLANK: begin
          if (bus.frame_tick && r_pend != EV_NONE) begin
            r_state     <= ST_MENU;
            r_principal <= 1'b1;
            r_cursor    <= '0;
            r_cursor_x  <= 10'd16;
            r_nuevo     <= 1'b1;
            r_idle      <= '0;
          end
        end
        ST_MENU: begin
          if (bus.frame_tick) begin
            r_idle <= '0;
            case (r_pend)
              EV_NONE: begin
                if (w_idle_inc == LP_TIMEOUT) begin
                  r_state     <= ST_BLANK;
                  r_principal <= 1'b0;
                end else begin
                  r_idle <= w_idle_inc;
                end
              end
              EV_LEFT: begin
                r_cursor   <= w_cur_dn;
                r_cursor_x <= cursor_pos(w_cur_dn);
              end
              EV_RIGHT: begin
                r_cursor   <= w_cur_up;
                r_cursor_x <= cursor_pos(w_cur_up);
              end
              EV_SELECT: begin
                r_state         <= ST_OPTION;
                r_opcion_activa <= r_cursor;
                r_principal     <= 1'b0;
                r_opcion        <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        ST_OPTION: begin
          if (bus.frame_tick && r_pend == EV_BACK) begin
            r_state    <= ST_CLOSE;
            r_opcion   <= 1'b0;
            r_cerrar   <= 1'b1;
            r_cursor   <= '0;
            r_cursor_x <= 10'd16;
          end
        end
        ST_CLOSE: begin
          r_state     <= ST_MENU;
          r_principal <= 1'b1;
          r_idle      <= '0;
        end
        default: r_state <= ST_BLANK;
      endcase
    end
  end

  assign bus.cursor_index             = r_cursor;
  assign bus.cursor_x                 = r_cursor_x;
  assign bus.pinta_pantalla_principal = r_principal;
  assign bus.pinta_pantalla_opcion    = r_opcion;
  assign bus.opcion_activa            = r_opcion_activa;
  assign bus.cerrar                   = r_cerrar;
  assign bus.nuevo                    = r_nuevo;

endmodule

// File: tb/tb_screen_sequencer.sv
// tb_screen_sequencer: directed stimulus with an event-level reference model
// compared against every output each cycle, plus hand-computed checkpoints.
module tb_screen_sequencer;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  screen_sequencer_if bus_if ();

  screen_sequencer #(.TIMEOUT_FRAMES(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0=blank 1=menu 2=option 3=close.
  // Pending event is kept as a rank (3 select, 2 back, 1 move, 0 none) and a
  // move direction; an event replaces the pending one if its rank is not lower.
  typedef struct {
    int mode;
    int cur;
    int opt;
    int idle;
    int prank;
    int pmove;
    bit nuevo;
    bit cerrar;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t s;
    s.mode = 0; s.cur = 0; s.opt = 0; s.idle = 0;
    s.prank = 0; s.pmove = 0; s.nuevo = 0; s.cerrar = 0;
    return s;
  endfunction

  function automatic int xpos(int i);
    case (i)
      0: return 16;
      1: return 93;
      2: return 180;
      3: return 480;
      default: return 557;
    endcase
  endfunction

  function automatic model_t step(model_t s, bit f, bit l, bit r, bit sel, bit b);
    model_t n;
    int crank, cmove, nc;
    n = s;
    n.nuevo = 0;
    n.cerrar = 0;
    crank = sel ? 3 : b ? 2 : (l != r) ? 1 : 0;
    cmove = l ? -1 : 1;
    if (s.mode == 3) begin
      n.mode = 1;
      n.idle = 0;
    end else if (f) begin
      if (s.mode == 0 && s.prank > 0) begin
        n.mode = 1; n.cur = 0; n.nuevo = 1; n.idle = 0;
      end else if (s.mode == 1) begin
        n.idle = 0;
        if (s.prank == 0) begin
          if (s.idle + 1 == TO) n.mode = 0;
          else n.idle = s.idle + 1;
        end else if (s.prank == 1) begin
          nc = s.cur + s.pmove;
`ifdef CURSOR_WRAP_EN
          if (nc > 4) nc = 0;
          if (nc < 0) nc = 4;
`else
          if (nc > 4) nc = 4;
          if (nc < 0) nc = 0;
`endif
          n.cur = nc;
        end else if (s.prank == 3) begin
          n.mode = 2; n.opt = s.cur;
        end
      end else if (s.mode == 2 && s.prank == 2) begin
        n.mode = 3; n.cerrar = 1; n.cur = 0;
      end
    end
    if (f) n.prank = 0;
    if (crank > 0 && crank >= n.prank) begin
      n.prank = crank;
      n.pmove = cmove;
    end
    return n;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) m <= model_reset();
    else m <= step(m, bus_if.frame_tick, bus_if.left_tick, bus_if.right_tick,
                   bus_if.select_tick, bus_if.back_tick);
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the rising edge
  always @(negedge clk) begin
    check("model cursor_index", int'(bus_if.cursor_index), m.cur);
    check("model cursor_x", int'(bus_if.cursor_x), xpos(m.cur));
    check("model principal", int'(bus_if.pinta_pantalla_principal), int'(m.mode == 1));
    check("model opcion", int'(bus_if.pinta_pantalla_opcion), int'(m.mode == 2));
    check("model cerrar", int'(bus_if.cerrar), int'(m.cerrar));
    check("model nuevo", int'(bus_if.nuevo), int'(m.nuevo));
    if (m.mode == 2)
      check("model opcion_activa", int'(bus_if.opcion_activa), m.opt);
  end

  // One clock of stimulus, inputs applied just after the rising edge
  task automatic cyc(input bit f, input bit l, input bit r, input bit s, input bit b);
    bus_if.frame_tick  = f;
    bus_if.left_tick   = l;
    bus_if.right_tick  = r;
    bus_if.select_tick = s;
    bus_if.back_tick   = b;
    @(posedge clk);
    #1;
    bus_if.frame_tick  = 1'b0;
    bus_if.left_tick   = 1'b0;
    bus_if.right_tick  = 1'b0;
    bus_if.select_tick = 1'b0;
    bus_if.back_tick   = 1'b0;
  endtask

  task automatic right_frame();
    cyc(0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0);
  endtask

  task automatic left_frame();
    cyc(0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus_if.frame_tick  = 1'b0;
    bus_if.left_tick   = 1'b0;
    bus_if.right_tick  = 1'b0;
    bus_if.select_tick = 1'b0;
    bus_if.back_tick   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset cursor_x", int'(bus_if.cursor_x), 16);
    check("reset cursor_index", int'(bus_if.cursor_index), 0);
    check("reset principal", int'(bus_if.pinta_pantalla_principal), 0);
    reset = 1'b0;

    // BLANK -> MENU
    right_frame();
    check("enter nuevo", int'(bus_if.nuevo), 1);
    check("enter principal", int'(bus_if.pinta_pantalla_principal), 1);
    check("enter cursor_x", int'(bus_if.cursor_x), 16);
    cyc(0, 0, 0, 0, 0);
    check("nuevo one cycle", int'(bus_if.nuevo), 0);

    // Cursor movement
    repeat (3) right_frame();
    check("idx3 cursor_index", int'(bus_if.cursor_index), 3);
    check("idx3 cursor_x", int'(bus_if.cursor_x), 480);
    repeat (2) right_frame();
`ifdef CURSOR_WRAP_EN
    check("right end cursor_x", int'(bus_if.cursor_x), 16);
    repeat (2) right_frame();
`else
    check("right end cursor_x", int'(bus_if.cursor_x), 557);
    repeat (2) left_frame();
`endif
    check("idx2 cursor_x", int'(bus_if.cursor_x), 180);

    // Select with a move in the same frame
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0);
    check("select opcion", int'(bus_if.pinta_pantalla_opcion), 1);
    check("select opcion_activa", int'(bus_if.opcion_activa), 2);
    check("select principal", int'(bus_if.pinta_pantalla_principal), 0);
    cyc(0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0);
    check("option ignores select", int'(bus_if.pinta_pantalla_opcion), 1);

    // Back -> CLOSE -> MENU
    cyc(0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0);
    check("close cerrar", int'(bus_if.cerrar), 1);
    check("close opcion", int'(bus_if.pinta_pantalla_opcion), 0);
    check("close principal", int'(bus_if.pinta_pantalla_principal), 0);
    cyc(0, 0, 0, 0, 0);
    check("after close cerrar", int'(bus_if.cerrar), 0);
    check("after close principal", int'(bus_if.pinta_pantalla_principal), 1);
    check("after close cursor", int'(bus_if.cursor_index), 0);

    // Simultaneous left+right discarded; later move wins; back ignored
    repeat (2) right_frame();
    cyc(0, 1, 1, 0, 0);
    cyc(1, 0, 0, 0, 0);
    check("l+r discarded", int'(bus_if.cursor_index), 2);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0);
    check("later move wins", int'(bus_if.cursor_index), 3);
    cyc(0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0);
    check("menu back ignored", int'(bus_if.pinta_pantalla_principal), 1);
    cyc(1, 0, 1, 0, 0);
    check("tick on frame deferred", int'(bus_if.cursor_index), 3);
    cyc(1, 0, 0, 0, 0);
    check("deferred tick applied", int'(bus_if.cursor_index), 4);

    // Idle timeout
    repeat (3) begin
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
    end
    check("before timeout", int'(bus_if.pinta_pantalla_principal), 1);
    cyc(1, 0, 0, 0, 0);
    check("timeout principal", int'(bus_if.pinta_pantalla_principal), 0);
    check("timeout opcion", int'(bus_if.pinta_pantalla_opcion), 0);
    cyc(1, 0, 0, 0, 0);
    check("blank stays idle", int'(bus_if.pinta_pantalla_principal), 0);

    // Left at index 0
    right_frame();
    left_frame();
`ifdef CURSOR_WRAP_EN
    check("left end cursor_x", int'(bus_if.cursor_x), 557);
`else
    check("left end cursor_x", int'(bus_if.cursor_x), 16);
`endif

    // Reset during OPTION with an event pending
    cyc(0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0);
    check("pre-reset opcion", int'(bus_if.pinta_pantalla_opcion), 1);
    cyc(0, 0, 1, 0, 0);
    #2 reset = 1'b1;
    #1;
    check("async reset opcion", int'(bus_if.pinta_pantalla_opcion), 0);
    check("async reset opcion_activa", int'(bus_if.opcion_activa), 0);
    check("async reset cursor_x", int'(bus_if.cursor_x), 16);
    @(posedge clk);
    #1 reset = 1'b0;
    cyc(1, 0, 0, 0, 0);
    check("pending lost on reset", int'(bus_if.pinta_pantalla_principal), 0);
    check("no nuevo after reset", int'(bus_if.nuevo), 0);
    repeat (2) cyc(0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
